// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel-rate divider, h/v raster counters and a registered
// output stage that lags the x/y pointers by exactly one pixel period.
module vga_timing_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rgb_in,
    output logic [9:0] x_ptr,
    output logic [9:0] y_ptr,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] r,
    output logic [2:0] g,
    output logic [1:0] b,
    output logic       video_on,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    logic [3:0] r_div;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_videoOn;
    logic [7:0] r_rgb;
    logic       r_frameStart;

    logic       w_pixTick;
    logic       w_hLast;
    logic       w_vLast;
    logic       w_hSyncAct;
    logic       w_vSyncAct;
    logic       w_visible;

    assign w_pixTick  = (r_div == 4'(CLK_DIV - 1));
    assign w_hLast    = (r_h == 10'(H_TOTAL - 1));
    assign w_vLast    = (r_v == 10'(V_TOTAL - 1));
    assign w_hSyncAct = (r_h >= 10'(H_VIS + H_FP)) && (r_h < 10'(H_VIS + H_FP + H_SYNC));
    assign w_vSyncAct = (r_v >= 10'(V_VIS + V_FP)) && (r_v < 10'(V_VIS + V_FP + V_SYNC));
    assign w_visible  = (r_h < 10'(H_VIS)) && (r_v < 10'(V_VIS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_pixTick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 4'd1;
        end
    end

    // v advances only on the tick that closes the last pixel of a line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_pixTick) begin
            if (w_hLast) begin
                r_h <= '0;
                r_v <= w_vLast ? 10'd0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    // rgb_in is sampled on the tick, CLK_DIV-1 clks after h/v moved, so it already
    // belongs to the pixel being registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_videoOn    <= 1'b0;
            r_rgb        <= '0;
            r_frameStart <= 1'b0;
        end else begin
            r_frameStart <= w_pixTick && w_hLast && w_vLast;
            if (w_pixTick) begin
                r_hsync   <= ~w_hSyncAct;
                r_vsync   <= ~w_vSyncAct;
                r_videoOn <= w_visible;
                r_rgb     <= w_visible ? rgb_in : 8'h00;
            end
        end
    end

    assign x_ptr       = r_h;
    assign y_ptr       = r_v;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_videoOn;
    assign r           = r_rgb[7:5];
    assign g           = r_rgb[4:2];
    assign b           = r_rgb[1:0];
    assign frame_start = r_frameStart;

endmodule
